// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch front end.
// Issues one word-aligned fetch at a time to instruction memory, tags each
// response with its PC and queues {pc, instruction} pairs for decode.
// A taken branch/jump (redirect) restarts fetching at the target, empties the
// queue and drops any response still in flight for the old path.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    // REQ: may present a request; WAIT: awaiting a response to keep;
    // FLUSH: awaiting a response that belongs to an abandoned path.
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       tag_q, tag_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0]       buf_data_q [BUF_DEPTH];
    logic [31:0]       buf_data_d [BUF_DEPTH];
    logic [31:0]       buf_pc_q   [BUF_DEPTH];
    logic [31:0]       buf_pc_d   [BUF_DEPTH];
    logic [31:0]       head_data_q, head_data_d;
    logic [31:0]       head_pc_q, head_pc_d;

    logic              req_fire;
    logic              push_en;
    logic              pop_en;
    logic [PTR_W-1:0]  rd_ptr_inc;
    logic [PTR_W-1:0]  wr_ptr_inc;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign imem_req_valid = (state_q == ST_REQ) && (count_q < DEPTH_C);
    assign imem_addr      = fetch_pc_q;
    assign instr_valid    = (count_q != '0);
    assign instr_data     = head_data_q;
    assign instr_pc       = head_pc_q;

    assign req_fire   = imem_req_valid && imem_req_ready;
    assign push_en    = (state_q == ST_WAIT) && imem_rsp_valid;
    assign pop_en     = instr_valid && instr_ready;
    assign rd_ptr_inc = ptr_next(rd_ptr_q);
    assign wr_ptr_inc = ptr_next(wr_ptr_q);

    // Request/response sequencing and fetch PC; a redirect overrides the normal path.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        tag_d      = tag_q;
        case (state_q)
            ST_REQ: begin
                if (req_fire) begin
                    tag_d      = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_FLUSH: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            case (state_q)
                ST_REQ:   state_d = req_fire ? ST_FLUSH : ST_REQ;
                ST_WAIT,
                ST_FLUSH: state_d = imem_rsp_valid ? ST_REQ : ST_FLUSH;
                default:  state_d = ST_REQ;
            endcase
        end
    end

    // Instruction queue: push tagged responses, pop on decode, keep a registered copy of the head.
    always_comb begin
        buf_data_d  = buf_data_q;
        buf_pc_d    = buf_pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        head_data_d = head_data_q;
        head_pc_d   = head_pc_q;
        if (redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push_en) begin
                buf_data_d[wr_ptr_q] = imem_rsp_data;
                buf_pc_d[wr_ptr_q]   = tag_q;
                wr_ptr_d             = wr_ptr_inc;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_inc;
            end
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
            if (pop_en) begin
                if (count_q > ONE_C) begin
                    head_data_d = buf_data_q[rd_ptr_inc];
                    head_pc_d   = buf_pc_q[rd_ptr_inc];
                end else if (push_en) begin
                    head_data_d = imem_rsp_data;
                    head_pc_d   = tag_q;
                end
            end else if (push_en && (count_q == '0)) begin
                head_data_d = imem_rsp_data;
                head_pc_d   = tag_q;
            end
        end
    end

    // State, PC and queue registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_REQ;
            fetch_pc_q  <= RESET_PC;
            tag_q       <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            head_data_q <= '0;
            head_pc_q   <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            tag_q       <= tag_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            head_data_q <= head_data_d;
            head_pc_q   <= head_pc_d;
            buf_data_q  <= buf_data_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl (RESET_PC=0, BUF_DEPTH=2).
// A behavioural instruction memory answers each accepted request after a
// configurable delay with a word derived from the address; directed scenarios
// and a randomized run compare the decode-side stream against the rule that,
// between redirects, instructions appear at consecutive PCs from the target.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural memory state
    bit          mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int          mem_delay_cfg = 0;
    bit          spur_en = 1'b0;
    bit          last_hs = 1'b0;
    logic [31:0] last_hs_addr = '0;
    int          n_hs = 0;
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_data_q[$];

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .BUF_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0019_660D) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic set_idle();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        mem_pend = 1'b0;
        mem_cnt  = 0;
        n_hs     = 0;
        pop_pc_q.delete();
        pop_data_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle: at the falling edge, drive memory/decode/redirect inputs and
    // note what the DUT will see at the following rising edge.
    task automatic step(input bit rdy, input bit irdy, input bit redir, input logic [31:0] tgt);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_pend       = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (spur_en && ($urandom_range(0, 7) == 0)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        imem_req_ready = rdy;
        instr_ready    = irdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        last_hs        = imem_req_valid && rdy;
        last_hs_addr   = imem_addr;
        if (last_hs) begin
            n_hs++;
            mem_pend = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = (mem_delay_cfg < 0) ? int'($urandom_range(0, 2)) : mem_delay_cfg;
        end
        if (instr_valid && irdy && !redir) begin
            pop_pc_q.push_back(instr_pc);
            pop_data_q.push_back(instr_data);
        end
    endtask

    task automatic test_reset();
        do_reset();
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        #7;
        set_idle();
        n_cmp++;
        if (instr_pc !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_pre_head: got %h expected %h", instr_pc, 32'h0);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid);
        end
        n_cmp++;
        if (instr_data !== 32'h0 || instr_pc !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_head: got %h/%h expected 0/0", instr_data, instr_pc);
        end
        n_cmp++;
        if (imem_addr !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_addr: got %h expected %h", imem_addr, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_first_req: got %b/%h expected 1/%h", imem_req_valid, imem_addr, 32'h0);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 1, 0, '0);
        n_cmp++;
        if (n_hs != 6) begin
            n_fail++; $display("[TB] FAIL stream_requests: got %0d expected %0d", n_hs, 6);
        end
        n_cmp++;
        if (pop_pc_q.size() != 5) begin
            n_fail++; $display("[TB] FAIL stream_pops: got %0d expected %0d", pop_pc_q.size(), 5);
        end
        if (pop_pc_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (pop_pc_q[i] !== 32'(4 * i)) begin
                    n_fail++; $display("[TB] FAIL stream_pc%0d: got %h expected %h", i, pop_pc_q[i], 32'(4 * i));
                end
                n_cmp++;
                if (pop_data_q[i] !== mem_word(32'(4 * i))) begin
                    n_fail++; $display("[TB] FAIL stream_data%0d: got %h expected %h", i, pop_data_q[i], mem_word(32'(4 * i)));
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, '0);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, '0);
            n_cmp++;
            if (imem_req_valid !== 1'b0) begin
                n_fail++; $display("[TB] FAIL stall_req_off: got %b expected 0", imem_req_valid);
            end
        end
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            n_fail++; $display("[TB] FAIL stall_head: got %b/%h expected 1/%h", instr_valid, instr_pc, 32'h0);
        end
        step(0, 1, 0, '0);
        step(0, 0, 0, '0);
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin
            n_fail++; $display("[TB] FAIL stall_resume: got %b/%h expected 1/%h", imem_req_valid, imem_addr, 32'h8);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        mem_delay_cfg = 3;
        step(1, 0, 0, '0);
        step(0, 0, 1, 32'h0000_0103);
        step(0, 0, 0, '0);
        n_cmp++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rdw_flush: got req %b instr %b expected 0/0", imem_req_valid, instr_valid);
        end
        step(0, 0, 0, '0);
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rdw_hold: got %b expected 0", imem_req_valid);
        end
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rdw_target: got %b/%h/%b expected 1/%h/0", imem_req_valid, imem_addr, instr_valid, 32'h100);
        end
        mem_delay_cfg = 0;
    endtask

    task automatic test_redirect_rsp();
        do_reset();
        step(1, 0, 0, '0);
        step(0, 0, 1, 32'h0000_0200);
        step(0, 0, 0, '0);
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rdr_target: got %b/%h/%b expected 1/%h/0", imem_req_valid, imem_addr, instr_valid, 32'h200);
        end
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr_data !== mem_word(32'h200)) begin
            n_fail++; $display("[TB] FAIL rdr_first: got %b/%h/%h expected 1/%h/%h", instr_valid, instr_pc, instr_data, 32'h200, mem_word(32'h200));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(0, 1, 1, 32'hFFFF_FFFF);
        step(0, 1, 0, '0);
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("[TB] FAIL wrap_latency: got %b/%h expected 1/%h", imem_req_valid, imem_addr, 32'hFFFF_FFFC);
        end
        for (int i = 0; i < 8; i++) step(1, 1, 0, '0);
        n_cmp++;
        if (pop_pc_q.size() < 2) begin
            n_fail++; $display("[TB] FAIL wrap_count: got %0d expected at least %0d", pop_pc_q.size(), 2);
        end else begin
            n_cmp++;
            if (pop_pc_q[0] !== 32'hFFFF_FFFC || pop_pc_q[1] !== 32'h0) begin
                n_fail++; $display("[TB] FAIL wrap_pcs: got %h,%h expected %h,%h", pop_pc_q[0], pop_pc_q[1], 32'hFFFF_FFFC, 32'h0);
            end
            n_cmp++;
            if (pop_data_q[1] !== mem_word(32'h0)) begin
                n_fail++; $display("[TB] FAIL wrap_data: got %h expected %h", pop_data_q[1], mem_word(32'h0));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_delay_cfg = 2;
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        step(0, 0, 0, '0);
        n_cmp++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rmid_after: got %b/%h/%b expected 1/%h/0", imem_req_valid, imem_addr, instr_valid, 32'h0);
        end
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        n_cmp++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("[TB] FAIL rmid_stale: got %b/%b/%h expected 0/1/%h", instr_valid, imem_req_valid, imem_addr, 32'h0);
        end
        mem_delay_cfg = 0;
    endtask

    // Random traffic: requests follow the sequential path from the last
    // redirect target, decode sees the same path in order with matching words,
    // and a presented request is held until accepted unless redirected.
    task automatic test_random();
        logic [31:0] exp_req_pc;
        logic [31:0] exp_pop_pc;
        logic [31:0] pc;
        logic [31:0] d;
        logic [31:0] tgt;
        logic [31:0] prev_addr;
        bit          redir;
        bit          prev_valid;
        bit          prev_hs;
        bit          prev_redir;
        int          total_pops;
        do_reset();
        mem_delay_cfg = -1;
        spur_en       = 1'b1;
        exp_req_pc    = 32'h0;
        exp_pop_pc    = 32'h0;
        prev_valid    = 1'b0;
        prev_hs       = 1'b0;
        prev_redir    = 1'b0;
        prev_addr     = '0;
        total_pops    = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            redir = ($urandom_range(0, 19) == 0);
            tgt   = $urandom;
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), redir, tgt);
            if (prev_valid && !prev_hs && !prev_redir) begin
                n_cmp++;
                if (imem_req_valid !== 1'b1 || imem_addr !== prev_addr) begin
                    n_fail++; $display("[TB] FAIL rnd_hold: got %b/%h expected 1/%h", imem_req_valid, imem_addr, prev_addr);
                end
            end
            if (last_hs) begin
                n_cmp++;
                if (last_hs_addr !== exp_req_pc) begin
                    n_fail++; $display("[TB] FAIL rnd_req_addr: got %h expected %h", last_hs_addr, exp_req_pc);
                end
                exp_req_pc = exp_req_pc + 32'd4;
            end
            while (pop_pc_q.size() > 0) begin
                pc = pop_pc_q.pop_front();
                d  = pop_data_q.pop_front();
                total_pops++;
                n_cmp++;
                if (pc !== exp_pop_pc) begin
                    n_fail++; $display("[TB] FAIL rnd_pop_pc: got %h expected %h", pc, exp_pop_pc);
                end
                n_cmp++;
                if (d !== mem_word(pc)) begin
                    n_fail++; $display("[TB] FAIL rnd_pop_data: got %h expected %h", d, mem_word(pc));
                end
                exp_pop_pc = exp_pop_pc + 32'd4;
            end
            if (redir) begin
                exp_req_pc = {tgt[31:2], 2'b00};
                exp_pop_pc = {tgt[31:2], 2'b00};
            end
            prev_valid = imem_req_valid;
            prev_hs    = last_hs;
            prev_redir = redir;
            prev_addr  = imem_addr;
        end
        n_cmp++;
        if (total_pops < 100) begin
            n_fail++; $display("[TB] FAIL rnd_progress: got %0d expected at least %0d", total_pops, 100);
        end
        spur_en       = 1'b0;
        mem_delay_cfg = 0;
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] fetch_ctrl bench start");
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
